// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one memory bus between fetch (port 0) and data (port 1).
// Latency: request accepted at edge t issues MEM_exec in the cycle after t+1; completion pulses the cycle after MEM_data_ready.
// Backpressure: one-entry latch per port, O_reqN_ready low while occupied; issue stalls while MEM_ready is low in IDLE.
module mem_arbiter (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_req0_exec,
  input  logic        I_req0_write,
  input  logic [1:0]  I_req0_size,
  input  logic [15:0] I_req0_addr,
  input  logic [15:0] I_req0_data,
  input  logic        I_req1_exec,
  input  logic        I_req1_write,
  input  logic [1:0]  I_req1_size,
  input  logic [15:0] I_req1_addr,
  input  logic [15:0] I_req1_data,
  output logic        O_req0_ready,
  output logic        O_req1_ready,
  output logic [15:0] O_req0_data,
  output logic [15:0] O_req1_data,
  output logic        O_req0_data_ready,
  output logic        O_req1_data_ready,
  input  logic        MEM_ready,
  output logic        MEM_exec,
  output logic        MEM_write,
  output logic [1:0]  MEM_size,
  output logic [15:0] MEM_addr,
  output logic [15:0] MEM_data_out,
  input  logic [15:0] MEM_data_in,
  input  logic        MEM_data_ready
);

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   pend0, pend1;
  logic   last;
  logic   grant, grant_nxt;
  logic   issue, done;
  logic   acc0, acc1;
  req_t   lat0, lat1, mem_q;

  assign acc0 = I_req0_exec & ~pend0;
  assign acc1 = I_req1_exec & ~pend1;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    issue     = 1'b0;
    done      = 1'b0;
    MEM_exec  = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie the port that did not win last time goes next.
        if ((pend0 | pend1) && MEM_ready) begin
          issue     = 1'b1;
          state_nxt = S_ISSUE;
          grant_nxt = (pend0 && pend1) ? ~last : pend1;
        end
      end
      S_ISSUE: begin
        MEM_exec  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (MEM_data_ready) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state             <= S_IDLE;
      pend0             <= 1'b0;
      pend1             <= 1'b0;
      last              <= 1'b1;
      grant             <= 1'b0;
      lat0              <= '0;
      lat1              <= '0;
      mem_q             <= '0;
      O_req0_data       <= '0;
      O_req1_data       <= '0;
      O_req0_data_ready <= 1'b0;
      O_req1_data_ready <= 1'b0;
    end else begin
      state             <= state_nxt;
      grant             <= grant_nxt;
      O_req0_data_ready <= 1'b0;
      O_req1_data_ready <= 1'b0;
      if (acc0) begin
        pend0 <= 1'b1;
        lat0  <= {I_req0_write, I_req0_size, I_req0_addr, I_req0_data};
      end
      if (acc1) begin
        pend1 <= 1'b1;
        lat1  <= {I_req1_write, I_req1_size, I_req1_addr, I_req1_data};
      end
      if (issue) begin
        mem_q <= grant_nxt ? lat1 : lat0;
        last  <= grant_nxt;
      end
      // A port cannot be accepting while it owns the bus, so no clash with the pend set above.
      if (done) begin
        if (grant) begin
          pend1             <= 1'b0;
          O_req1_data_ready <= 1'b1;
          if (!mem_q.write) O_req1_data <= MEM_data_in;
        end else begin
          pend0             <= 1'b0;
          O_req0_data_ready <= 1'b1;
          if (!mem_q.write) O_req0_data <= MEM_data_in;
        end
      end
    end
  end

  assign O_req0_ready = ~pend0;
  assign O_req1_ready = ~pend1;
  assign MEM_write    = mem_q.write;
  assign MEM_size     = mem_q.size;
  assign MEM_addr     = mem_q.addr;
  assign MEM_data_out = mem_q.data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, checked against a
// transaction-level model of the per-port latches, round-robin choice and completions.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        I_reset;
  logic        I_req0_exec, I_req0_write, I_req1_exec, I_req1_write;
  logic [1:0]  I_req0_size, I_req1_size;
  logic [15:0] I_req0_addr, I_req0_data, I_req1_addr, I_req1_data;
  logic        O_req0_ready, O_req1_ready, O_req0_data_ready, O_req1_data_ready;
  logic [15:0] O_req0_data, O_req1_data;
  logic        MEM_ready, MEM_exec, MEM_write, MEM_data_ready;
  logic [1:0]  MEM_size;
  logic [15:0] MEM_addr, MEM_data_out, MEM_data_in;

  mem_arbiter dut (
    .I_clk(clk), .I_reset(I_reset),
    .I_req0_exec(I_req0_exec), .I_req0_write(I_req0_write), .I_req0_size(I_req0_size),
    .I_req0_addr(I_req0_addr), .I_req0_data(I_req0_data),
    .I_req1_exec(I_req1_exec), .I_req1_write(I_req1_write), .I_req1_size(I_req1_size),
    .I_req1_addr(I_req1_addr), .I_req1_data(I_req1_data),
    .O_req0_ready(O_req0_ready), .O_req1_ready(O_req1_ready),
    .O_req0_data(O_req0_data), .O_req1_data(O_req1_data),
    .O_req0_data_ready(O_req0_data_ready), .O_req1_data_ready(O_req1_data_ready),
    .MEM_ready(MEM_ready), .MEM_exec(MEM_exec), .MEM_write(MEM_write), .MEM_size(MEM_size),
    .MEM_addr(MEM_addr), .MEM_data_out(MEM_data_out),
    .MEM_data_in(MEM_data_in), .MEM_data_ready(MEM_data_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each port holds at most one request; one bus transaction at a time.
  bit          m_pend [2];
  logic [34:0] m_req  [2];
  logic [15:0] m_data [2];
  bit          m_last, m_idle, m_busy, m_owner, cur_exec, auto_resp;
  logic [34:0] m_issued;
  logic [34:0] obs_issue [$];
  int          obs_done  [$];

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_data[0] = '0; m_data[1] = '0;
    m_last = 1; m_idle = 1; m_busy = 0; m_owner = 0; cur_exec = 0; m_issued = '0;
  endtask

  task automatic do_reset();
    I_reset = 1; I_req0_exec = 0; I_req1_exec = 0; MEM_data_ready = 0;
    @(posedge clk); #1;
    I_reset = 0;
    model_reset();
    chk("rst_mem", 35'({MEM_exec, MEM_write, MEM_size, MEM_addr}), 35'(0));
    chk("rst_mem_dout", 35'(MEM_data_out), 35'(0));
    chk("rst_odata", 35'({O_req0_data, O_req1_data}), 35'(0));
    chk("rst_dready", 35'({O_req0_data_ready, O_req1_data_ready}), 35'(0));
    chk("rst_ready", 35'({O_req0_ready, O_req1_ready}), 35'(2'b11));
  endtask

  task automatic set_req(input int p, input bit w, input bit [1:0] s, input bit [15:0] a, input bit [15:0] d);
    if (p == 0) begin
      I_req0_exec = 1; I_req0_write = w; I_req0_size = s; I_req0_addr = a; I_req0_data = d;
    end else begin
      I_req1_exec = 1; I_req1_write = w; I_req1_size = s; I_req1_addr = a; I_req1_data = d;
    end
  endtask

  task automatic rand_req(input int p);
    set_req(p, 1'($urandom), 2'($urandom_range(1, 2)), 16'($urandom), 16'($urandom));
  endtask

  // One clock cycle: inputs set by the caller are live for the cycle ending at this edge.
  task automatic step();
    bit s_idle, s_p0, s_p1, s_mr, s_drw, a0, a1, e_exec, e_done, d_own, g;
    logic [34:0] f0, f1;
    logic [15:0] s_rd;
    if (auto_resp && $urandom_range(0, 2) == 0) begin
      MEM_data_ready = 1; MEM_data_in = 16'($urandom);
    end
    s_idle = m_idle; s_p0 = m_pend[0]; s_p1 = m_pend[1]; s_mr = MEM_ready;
    s_drw  = MEM_data_ready && m_busy && !cur_exec;
    s_rd   = MEM_data_in;
    a0 = I_req0_exec && !m_pend[0];
    a1 = I_req1_exec && !m_pend[1];
    f0 = {I_req0_write, I_req0_size, I_req0_addr, I_req0_data};
    f1 = {I_req1_write, I_req1_size, I_req1_addr, I_req1_data};
    @(posedge clk); #1;
    I_req0_exec = 0; I_req1_exec = 0; MEM_data_ready = 0;
    e_done = s_drw;
    d_own  = m_owner;
    if (e_done) begin
      m_pend[m_owner] = 0;
      if (!m_issued[34]) m_data[m_owner] = s_rd;
      m_busy = 0; m_idle = 1;
    end
    if (a0) begin m_pend[0] = 1; m_req[0] = f0; end
    if (a1) begin m_pend[1] = 1; m_req[1] = f1; end
    e_exec = s_idle && (s_p0 || s_p1) && s_mr;
    if (e_exec) begin
      g = (s_p0 && s_p1) ? !m_last : s_p1;
      m_last = g; m_owner = g; m_busy = 1; m_idle = 0; m_issued = m_req[g];
    end
    cur_exec = e_exec;
    if (MEM_exec === 1'b1) obs_issue.push_back({MEM_write, MEM_size, MEM_addr, MEM_data_out});
    if (O_req0_data_ready === 1'b1) obs_done.push_back(0);
    if (O_req1_data_ready === 1'b1) obs_done.push_back(1);
    chk("exec", 35'(MEM_exec), 35'(e_exec));
    chk("ready0", 35'(O_req0_ready), 35'(!m_pend[0]));
    chk("ready1", 35'(O_req1_ready), 35'(!m_pend[1]));
    chk("dready0", 35'(O_req0_data_ready), 35'(e_done && !d_own));
    chk("dready1", 35'(O_req1_data_ready), 35'(e_done && d_own));
    chk("rdata0", 35'(O_req0_data), 35'(m_data[0]));
    chk("rdata1", 35'(O_req1_data), 35'(m_data[1]));
    if (m_busy) chk("mem_fields", {MEM_write, MEM_size, MEM_addr, MEM_data_out}, m_issued);
  endtask

  task automatic drain(input int max);
    int n = 0;
    MEM_ready = 1; auto_resp = 1;
    while ((m_busy || m_pend[0] || m_pend[1]) && n < max) begin
      step(); n++;
    end
    chk("drain_budget", 35'(n < max), 35'(1));
  endtask

  initial begin
    I_req0_write = 0; I_req0_size = 0; I_req0_addr = 0; I_req0_data = 0;
    I_req1_write = 0; I_req1_size = 0; I_req1_addr = 0; I_req1_data = 0;
    MEM_ready = 1; MEM_data_in = 0; auto_resp = 0;
    do_reset();

    // Single read on port 0, response three cycles after the exec.
    set_req(0, 0, 2'd2, 16'h0010, 16'h0000);
    step();
    chk("t1_no_exec_yet", 35'(MEM_exec), 35'(0));
    step();
    chk("t1_exec", 35'(MEM_exec), 35'(1));
    chk("t1_addr", 35'({MEM_write, MEM_addr}), 35'({1'b0, 16'h0010}));
    repeat (3) step();
    MEM_data_ready = 1; MEM_data_in = 16'hBEEF;
    step();
    chk("t1_rdata", 35'(O_req0_data), 35'(16'hBEEF));
    chk("t1_pulse", 35'(O_req0_data_ready), 35'(1));
    step();
    chk("t1_pulse_once", 35'(O_req0_data_ready), 35'(0));
    chk("t1_ready_back", 35'(O_req0_ready), 35'(1));
    chk("t1_exec_count", 35'(obs_issue.size()), 35'(1));

    // Simultaneous read on port 0 and write on port 1.
    do_reset(); obs_issue.delete();
    set_req(0, 0, 2'd2, 16'h0100, 16'h0000);
    set_req(1, 1, 2'd2, 16'h0200, 16'h1234);
    auto_resp = 1;
    step();
    drain(80);
    chk("t2_exec_count", 35'(obs_issue.size()), 35'(2));
    if (obs_issue.size() >= 2) begin
      chk("t2_first_addr", 35'(obs_issue[0][31:16]), 35'(16'h0100));
      chk("t2_second", obs_issue[1], {1'b1, 2'd2, 16'h0200, 16'h1234});
    end
    chk("t2_port1_data", 35'(O_req1_data), 35'(0));

    // Fairness with both ports re-requesting immediately after each completion.
    do_reset(); obs_done.delete(); auto_resp = 1;
    for (int n = 0; n < 300 && obs_done.size() < 6; n++) begin
      if (O_req0_ready) rand_req(0);
      if (O_req1_ready) rand_req(1);
      step();
    end
    chk("t3_done_count", 35'(obs_done.size() >= 6), 35'(1));
    for (int i = 0; i < 6 && i < obs_done.size(); i++)
      chk($sformatf("t3_grant%0d", i), 35'(obs_done[i]), 35'(i % 2));
    drain(80);

    // MEM_ready held low with port 1 pending.
    do_reset(); obs_issue.delete(); auto_resp = 0; MEM_ready = 0;
    set_req(1, 0, 2'd1, 16'h0300, 16'h0000);
    step();
    repeat (5) step();
    chk("t4_stalled", 35'(obs_issue.size()), 35'(0));
    MEM_ready = 1;
    step();
    chk("t4_exec", 35'(MEM_exec), 35'(1));
    chk("t4_addr", 35'(MEM_addr), 35'(16'h0300));
    drain(60);

    // Request while latch full is dropped; stale MEM_data_ready in IDLE is ignored.
    do_reset(); obs_issue.delete(); auto_resp = 0;
    set_req(0, 0, 2'd2, 16'h0400, 16'h0000);
    step();
    set_req(0, 1, 2'd2, 16'h0500, 16'h5555);
    step();
    set_req(0, 1, 2'd2, 16'h0500, 16'h5555);
    step();
    drain(60);
    chk("t5_one_exec", 35'(obs_issue.size()), 35'(1));
    if (obs_issue.size() >= 1) chk("t5_addr", 35'(obs_issue[0][31:16]), 35'(16'h0400));
    auto_resp = 0; step();
    MEM_data_ready = 1; MEM_data_in = 16'hDEAD;
    step();
    step();
    chk("t5_no_stale_pulse", 35'({O_req0_data_ready, O_req1_data_ready}), 35'(0));

    // Reset while port 0 is waiting for its response.
    do_reset(); auto_resp = 0; MEM_ready = 1;
    set_req(0, 0, 2'd2, 16'h0600, 16'h0000);
    repeat (3) step();
    chk("t6_in_wait", 35'({MEM_exec, MEM_addr}), 35'({1'b0, 16'h0600}));
    do_reset();
    MEM_data_ready = 1; MEM_data_in = 16'h7777;
    step();
    chk("t6_no_pulse", 35'(O_req0_data_ready), 35'(0));
    chk("t6_ready", 35'({O_req0_ready, O_req1_ready}), 35'(2'b11));
    chk("t6_mem_zero", {MEM_write, MEM_size, MEM_addr, MEM_data_out}, 35'(0));
    chk("t6_exec_zero", 35'(MEM_exec), 35'(0));

    // Randomized traffic, stalls and stray responses.
    do_reset(); auto_resp = 1;
    repeat (800) begin
      MEM_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) rand_req(0);
      if ($urandom_range(0, 1) == 0) rand_req(1);
      step();
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
